// File: rtl/bilinear_interpolator_if.sv
// Sample/result bundle between the BRAM pixel reader, the bilinear interpolator and the
// undistorted-image writer.
interface bilinear_interpolator_if #(
    parameter int unsigned BITS_PER_PIXEL = 8,
    parameter int unsigned FRAC_BITS      = 4,
    parameter int unsigned IMG_WIDTH      = 320,
    parameter int unsigned IMG_HEIGHT     = 240
);
    localparam int unsigned XW = $clog2(IMG_WIDTH);
    localparam int unsigned YW = $clog2(IMG_HEIGHT);

    logic                      in_valid;
    logic [BITS_PER_PIXEL-1:0] pixel_tl;
    logic [BITS_PER_PIXEL-1:0] pixel_tr;
    logic [BITS_PER_PIXEL-1:0] pixel_bl;
    logic [BITS_PER_PIXEL-1:0] pixel_br;
    logic [FRAC_BITS-1:0]      frac_x;
    logic [FRAC_BITS-1:0]      frac_y;
    logic                      in_oob;
    logic [BITS_PER_PIXEL-1:0] pixel_out;
    logic                      out_valid;
    logic [XW-1:0]             out_x;
    logic [YW-1:0]             out_y;
    logic                      frame_done;

    modport master (
        output in_valid, pixel_tl, pixel_tr, pixel_bl, pixel_br, frac_x, frac_y, in_oob,
        input  pixel_out, out_valid, out_x, out_y, frame_done
    );

    modport slave (
        input  in_valid, pixel_tl, pixel_tr, pixel_bl, pixel_br, frac_x, frac_y, in_oob,
        output pixel_out, out_valid, out_x, out_y, frame_done
    );
endinterface

// File: rtl/bilinear_interpolator.sv
// Three-stage bilinear interpolator: horizontal blend, vertical blend, round/clamp/fill,
// with an output raster position tracker and end-of-frame pulse.
module bilinear_interpolator #(
    parameter int unsigned BITS_PER_PIXEL = 8,
    parameter int unsigned FRAC_BITS      = 4,
    parameter int unsigned IMG_WIDTH      = 320,
    parameter int unsigned IMG_HEIGHT     = 240,
    parameter int unsigned FILL_VALUE     = 0
) (
    input logic                   clk,
    input logic                   rst,
    bilinear_interpolator_if.slave bus
);
    localparam int unsigned XW = $clog2(IMG_WIDTH);
    localparam int unsigned YW = $clog2(IMG_HEIGHT);
    localparam int unsigned WT = 1 << FRAC_BITS;
    localparam int unsigned SW = BITS_PER_PIXEL + FRAC_BITS + 1;
    localparam int unsigned VW = BITS_PER_PIXEL + 2 * FRAC_BITS + 1;
    localparam int unsigned RW = VW + 1;

    localparam logic [RW-1:0]             RoundHalf = RW'(1 << (2 * FRAC_BITS - 1));
    localparam logic [RW-1:0]             PixMax    = RW'((1 << BITS_PER_PIXEL) - 1);
    localparam logic [BITS_PER_PIXEL-1:0] FillPix   = BITS_PER_PIXEL'(FILL_VALUE);
    localparam logic [XW-1:0]             LastX     = XW'(IMG_WIDTH - 1);
    localparam logic [YW-1:0]             LastY     = YW'(IMG_HEIGHT - 1);

    // Stage 1: horizontal blend
    logic [FRAC_BITS:0]   w_wx0, w_wx1;
    logic [SW-1:0]        w_top, w_bot;
    logic                 r_vld1, r_oob1;
    logic [FRAC_BITS-1:0] r_fy1;
    logic [SW-1:0]        r_top, r_bot;

    assign w_wx0 = (FRAC_BITS + 1)'(WT) - {1'b0, bus.frac_x};
    assign w_wx1 = {1'b0, bus.frac_x};
    assign w_top = SW'(bus.pixel_tl) * SW'(w_wx0) + SW'(bus.pixel_tr) * SW'(w_wx1);
    assign w_bot = SW'(bus.pixel_bl) * SW'(w_wx0) + SW'(bus.pixel_br) * SW'(w_wx1);

    // Stage 2: vertical blend
    logic [FRAC_BITS:0] w_wy0, w_wy1;
    logic [VW-1:0]      w_v;
    logic               r_vld2, r_oob2;
    logic [VW-1:0]      r_v;

    assign w_wy0 = (FRAC_BITS + 1)'(WT) - {1'b0, r_fy1};
    assign w_wy1 = {1'b0, r_fy1};
    assign w_v   = VW'(r_top) * VW'(w_wy0) + VW'(r_bot) * VW'(w_wy1);

    // Stage 3: round-half-up, clamp, fill substitution
    logic [RW-1:0]             w_round, w_shift;
    logic [BITS_PER_PIXEL-1:0] w_pix;

    assign w_round = {1'b0, r_v} + RoundHalf;
    assign w_shift = w_round >> (2 * FRAC_BITS);

    always_comb begin
        w_pix = w_shift[BITS_PER_PIXEL-1:0];
        if (w_shift > PixMax) begin
            w_pix = PixMax[BITS_PER_PIXEL-1:0];
        end
        if (r_oob2) begin
            w_pix = FillPix;
        end
    end

    logic                      r_out_valid, r_frame_done;
    logic [BITS_PER_PIXEL-1:0] r_pixel;
    logic [XW-1:0]             r_out_x, r_next_x;
    logic [YW-1:0]             r_out_y, r_next_y;
    logic                      w_last_x, w_last_y;

    assign w_last_x = (r_next_x == LastX);
    assign w_last_y = (r_next_y == LastY);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vld1       <= 1'b0;
            r_oob1       <= 1'b0;
            r_fy1        <= '0;
            r_top        <= '0;
            r_bot        <= '0;
            r_vld2       <= 1'b0;
            r_oob2       <= 1'b0;
            r_v          <= '0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_pixel      <= '0;
            r_out_x      <= '0;
            r_out_y      <= '0;
            r_next_x     <= '0;
            r_next_y     <= '0;
        end else begin
            r_vld1       <= bus.in_valid;
            r_vld2       <= r_vld1;
            r_out_valid  <= r_vld2;
            r_frame_done <= r_vld2 && w_last_x && w_last_y;
            if (bus.in_valid) begin
                r_oob1 <= bus.in_oob;
                r_fy1  <= bus.frac_y;
                r_top  <= w_top;
                r_bot  <= w_bot;
            end
            if (r_vld1) begin
                r_oob2 <= r_oob1;
                r_v    <= w_v;
            end
            // Position is presented from the pre-computed next slot so it is stable all cycle.
            if (r_vld2) begin
                r_pixel  <= w_pix;
                r_out_x  <= r_next_x;
                r_out_y  <= r_next_y;
                r_next_x <= w_last_x ? '0 : r_next_x + XW'(1);
                if (w_last_x) begin
                    r_next_y <= w_last_y ? '0 : r_next_y + YW'(1);
                end
            end
        end
    end

    assign bus.pixel_out  = r_pixel;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_x      = r_out_x;
    assign bus.out_y      = r_out_y;
    assign bus.frame_done = r_frame_done;
endmodule

// File: tb/tb_bilinear_interpolator.sv
// Directed and streaming bench for bilinear_interpolator using an expected-result queue.
module tb_bilinear_interpolator;
    localparam int BPP  = 8;
    localparam int FB   = 4;
    localparam int IW   = 320;
    localparam int IH   = 240;
    localparam int FILL = 0;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    bilinear_interpolator_if #(
        .BITS_PER_PIXEL(BPP), .FRAC_BITS(FB), .IMG_WIDTH(IW), .IMG_HEIGHT(IH)
    ) bus ();

    bilinear_interpolator #(
        .BITS_PER_PIXEL(BPP), .FRAC_BITS(FB), .IMG_WIDTH(IW), .IMG_HEIGHT(IH),
        .FILL_VALUE(FILL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        int pix;
        int x;
        int y;
        int fd;
        int due;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   tests   = 0;
    int   failed  = 0;
    int   cyc     = 0;
    int   pos_x   = 0;
    int   pos_y   = 0;
    int   fd_seen = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // exp_pix < 0 asks the reference model for the expected pixel.
    task automatic drive(input int tl, input int tr, input int bl, input int br,
                         input int fx, input int fy, input bit oob, input int exp_pix);
        exp_t e;
        int   s;
        bus.in_valid = 1'b1;
        bus.pixel_tl = 8'(tl);
        bus.pixel_tr = 8'(tr);
        bus.pixel_bl = 8'(bl);
        bus.pixel_br = 8'(br);
        bus.frac_x   = 4'(fx);
        bus.frac_y   = 4'(fy);
        bus.in_oob   = oob;
        if (exp_pix < 0) begin
            s = tl * (16 - fx) * (16 - fy) + tr * fx * (16 - fy)
              + bl * (16 - fx) * fy + br * fx * fy;
            e.pix = oob ? FILL : (s + 128) / 256;
        end else begin
            e.pix = exp_pix;
        end
        e.x   = pos_x;
        e.y   = pos_y;
        e.fd  = (pos_x == IW - 1 && pos_y == IH - 1) ? 1 : 0;
        e.due = cyc + 3;
        q.push_back(e);
        if (pos_x == IW - 1) begin
            pos_x = 0;
            pos_y = (pos_y == IH - 1) ? 0 : pos_y + 1;
        end else begin
            pos_x++;
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_oob   = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (q.size() != 0 && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("drain_timeout", q.size(), 0);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        q.delete();
        pos_x = 0;
        pos_y = 0;
        idle(n);
        rst = 1'b1;
    endtask

    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("spurious_valid", 1, 0);
            end else begin
                mon_e = q.pop_front();
                chk("pixel", bus.pixel_out, mon_e.pix);
                chk("out_x", bus.out_x, mon_e.x);
                chk("out_y", bus.out_y, mon_e.y);
                chk("frame_done", bus.frame_done, mon_e.fd);
                chk("latency", cyc, mon_e.due);
            end
            if (bus.frame_done === 1'b1) fd_seen++;
        end else begin
            chk("fd_idle", bus.frame_done, 0);
        end
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.pixel_tl = '0;
        bus.pixel_tr = '0;
        bus.pixel_bl = '0;
        bus.pixel_br = '0;
        bus.frac_x   = '0;
        bus.frac_y   = '0;
        bus.in_oob   = 1'b0;
        idle(3);

        chk("rst_valid", bus.out_valid, 0);
        chk("rst_pixel", bus.pixel_out, 0);
        chk("rst_x", bus.out_x, 0);
        chk("rst_y", bus.out_y, 0);
        chk("rst_fd", bus.frame_done, 0);
        rst = 1'b1;
        idle(2);

        drive(200, 0, 0, 0, 0, 0, 1'b0, 200);
        drain();

        drive(10, 20, 30, 40, 8, 8, 1'b0, 25);
        drive(255, 255, 255, 255, 7, 9, 1'b0, 255);
        drain();

        drive(0, 100, 0, 100, 8, 0, 1'b0, 50);
        drive(0, 100, 0, 100, 15, 0, 1'b0, 94);
        drain();
        idle(3);
        chk("hold_pixel", bus.pixel_out, 94);

        drive(255, 255, 255, 255, 5, 11, 1'b1, FILL);
        for (int i = 0; i < 8; i++) begin
            drive($urandom_range(255), $urandom_range(255), $urandom_range(255),
                  $urandom_range(255), $urandom_range(15), $urandom_range(15),
                  (i == 3), -1);
        end
        drain();

        do_reset(2);
        idle(1);
        fd_seen = 0;
        for (int i = 0; i < IW * IH; i++) begin
            drive($urandom_range(255), $urandom_range(255), $urandom_range(255),
                  $urandom_range(255), $urandom_range(15), $urandom_range(15),
                  ($urandom_range(31) == 0), -1);
        end
        drive(77, 33, 180, 9, 6, 10, 1'b0, -1);
        drain();
        chk("fd_count", fd_seen, 1);

        drive(11, 22, 33, 44, 2, 3, 1'b0, -1);
        drive(99, 88, 77, 66, 4, 5, 1'b0, -1);
        do_reset(3);
        idle(6);
        drive(50, 50, 50, 50, 3, 5, 1'b0, 50);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
